floo_axis_chan_scheduler: RTL and testbench
===========================================

// Module: floo_axis_chan_scheduler
// PURPOSE
//  Shares the single outgoing AXIS link between three flit sources: narrow request, narrow
//  response and wide. It is the scheduler in front of the narrow/wide NoC bridge output mux.
//  It uses a two-class (NARROW/WIDE) FSM with runtime-configurable beat quotas, plus
//  round-robin between the two narrow sources. It holds the selection while a beat is stalled
//  and keeps wrapping per-source beat counters. It drives the grant/select only; no data.
// PARAMETERS
//  QuotaWidth   4   width of the quota config ports and the beat-in-class counter
//  StatWidth    32  width of each per-source beat statistics counter
// PORTS
//  clk_i              in   1           clock
//  rst_i              in   1           reset, asynchronous, active-high
//  nreq_valid_i       in   1           narrow request flit pending
//  nrsp_valid_i       in   1           narrow response flit pending
//  wide_valid_i       in   1           wide flit pending
//  nreq_gnt_o         out  1           narrow request flit accepted this cycle
//  nrsp_gnt_o         out  1           narrow response flit accepted this cycle
//  wide_gnt_o         out  1           wide flit accepted this cycle
//  out_valid_o        out  1           AXIS output tvalid
//  out_ready_i        in   1           AXIS output tready
//  sel_o              out  2           sched_sel_e; mux select for the AXIS payload/hdr/strb
//  cfg_narrow_quota_i in   QuotaWidth  max consecutive narrow beats while wide waits (0 == 1)
//  cfg_wide_quota_i   in   QuotaWidth  max consecutive wide beats while narrow waits (0 == 1)
//  stat_clr_i         in   1           synchronous clear of all statistics counters
//  stat_nreq_o        out  StatWidth   narrow request beats sent, wraps
//  stat_nrsp_o        out  StatWidth   narrow response beats sent, wraps
//  stat_wide_o        out  StatWidth   wide beats sent, wraps
// BEHAVIOUR
//  - Reset (async, rst_i=1) state values:
//    - class_q=narrowChan, cnt_q=0, rr_q=NREQ, lock_q=0, stats=0.
//    - While rst_i=1: out_valid_o=0 and all gnt=0; sel_o=SEL_NREQ.
//  - Handshake: hs = out_valid_o & out_ready_i. Each gnt equals hs & (sel_o == that source).
//  - NARROW class:
//    - out_valid_o = nreq_valid_i | nrsp_valid_i.
//    - If both are valid, pick rr_q; otherwise pick the valid one.
//    - On a narrow hs, rr_q <= the source not granted.
//  - WIDE class:
//    - out_valid_o = wide_valid_i; sel_o = SEL_WIDE.
//  - Stall lock: if out_valid_o & !out_ready_i, set lock_q and sel_q <= sel_o.
//    - While lock_q=1, sel_o = sel_q, regardless of new valids or rr_q.
//    - lock_q clears on hs.
//    - The AXIS stream stays stable across a stall.
//  - Zero-cycle latency: valid in the current class -> out_valid_o in the same cycle.
//  - Quota: cnt_q increments on each hs in the current class; it saturates at the all-ones value.
//  - Switch NARROW->WIDE (registered, cnt_q <= 0). Condition: wide_valid_i and either
//    a) hs and cnt_q+1 >= max(cfg_narrow_quota_i,1): no bubble, next cycle serves wide; or
//    b) no narrow valid and lock_q=0: out_valid_o=0 for this single cycle.
//  - WIDE->NARROW: symmetric, using cfg_wide_quota_i and (nreq_valid_i|nrsp_valid_i).
//  - No switch while the other class is idle; the current class runs unbounded.
//  - Quota ports are used live. A change takes effect at the next comparison; the current
//    cnt_q is kept.
//  - Stats:
//    - Each counter increments on its source's gnt and wraps 2^StatWidth-1 -> 0.
//    - stat_clr_i has priority over a same-cycle increment; the result is 0.
//  - Reset mid-beat (locked stall):
//    - All state returns to reset values and no grant is issued.
//    - Sources must re-present their flit.
// STRUCTURE
//  - noc_bridge_narrow_wide_pkg: reuse selected_channel_type_e (narrowChan/wideChan).
//  - Add sched_sel_e to the package: SEL_NREQ=2'b00, SEL_NRSP=2'b01, SEL_WIDE=2'b10.
//  - The output mux maps sel_o onto hdr: narrow_request/narrow_response/wide_channel.
//  - Sub-module floo_sched_stat_cnt, instantiated 3x: one StatWidth wrapping counter with clr.
//  - Use asynchronous active-high reset registers throughout.
// TESTING
//  - Reset:
//    - rst_i=1 with all valids=1 -> out_valid_o=0, gnts=0, sel_o=SEL_NREQ, stats=0.
//    - Release reset -> nreq is granted in the first cycle.
//  - RR:
//    - nreq and nrsp valid, ready=1, wide=0 for 6 cycles -> grants alternate NREQ,NRSP,... (3 each).
//  - Quota:
//    - cfg_narrow_quota=2, cfg_wide_quota=3; all valid, ready=1.
//    - Grant order: N,N,W,W,W,N,N,W..., with no bubble at switches.
//  - Idle switch:
//    - Only wide_valid=1 starting from NARROW -> out_valid_o=0 for 1 cycle, then wide is granted.
//  - Stall lock:
//    - nrsp offered with ready=0; nreq rises next cycle with rr_q=NREQ.
//    - sel_o stays SEL_NRSP until ready=1; nrsp_gnt_o pulses once.
//  - Stats:
//    - Preload via 2^StatWidth-1 wide beats (StatWidth=4 build), then 1 more -> stat_wide_o=0.
//    - stat_clr_i together with a grant -> 0.

Source files
------------

// File: rtl/noc_bridge_narrow_wide_pkg.sv
// Shared types for the narrow/wide NoC bridge.
//   selected_channel_type_e : which traffic class currently owns the AXIS link
//   sched_sel_e             : scheduler mux select for the AXIS payload/hdr/strb
//   hdr_e                   : header tag the output mux places on the link
package noc_bridge_narrow_wide_pkg;

  typedef enum logic {
    narrowChan = 1'b0,
    wideChan   = 1'b1
  } selected_channel_type_e;

  typedef enum logic [1:0] {
    SEL_NREQ = 2'b00,
    SEL_NRSP = 2'b01,
    SEL_WIDE = 2'b10
  } sched_sel_e;

  typedef enum logic [1:0] {
    narrow_request  = 2'b00,
    narrow_response = 2'b01,
    wide_channel    = 2'b10
  } hdr_e;

  // Output mux helper: scheduler select onto the link header tag.
  function automatic hdr_e sel_to_hdr(input sched_sel_e sel);
    case (sel)
      SEL_NRSP: sel_to_hdr = narrow_response;
      SEL_WIDE: sel_to_hdr = wide_channel;
      default:  sel_to_hdr = narrow_request;
    endcase
  endfunction

endpackage

// File: rtl/floo_sched_stat_cnt.sv
// Per-source beat statistics counter. Wraps from all-ones to zero.
//   clk_i  in   clock
//   rst_i  in   asynchronous active-high reset
//   clr_i  in   synchronous clear, wins over a same-cycle increment
//   inc_i  in   count one beat
//   cnt_o  out  current count
module floo_sched_stat_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/floo_axis_chan_scheduler.sv
// Scheduler for the single outgoing AXIS link shared by narrow request, narrow
// response and wide flit sources. Two traffic classes (NARROW/WIDE) with live
// beat quotas, round-robin between the two narrow sources, selection held
// across a stalled beat. Drives grant/select only, no data.
//   clk_i, rst_i                      clock, async active-high reset
//   nreq/nrsp/wide_valid_i            source flit pending
//   nreq/nrsp/wide_gnt_o              source flit accepted this cycle
//   out_valid_o, out_ready_i          AXIS tvalid/tready
//   sel_o                             sched_sel_e mux select
//   cfg_narrow/wide_quota_i           max consecutive beats while the other class waits (0 == 1)
//   stat_clr_i                        clear all statistics counters
//   stat_nreq/nrsp/wide_o             wrapping beat counters per source
//
// state (class_q) | meaning
// narrowChan      | narrow request/response share the link, round-robin
// wideChan        | wide source owns the link
module floo_axis_chan_scheduler
  import noc_bridge_narrow_wide_pkg::*;
#(
  parameter int unsigned QuotaWidth = 4,
  parameter int unsigned StatWidth  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  nreq_valid_i,
  input  logic                  nrsp_valid_i,
  input  logic                  wide_valid_i,
  output logic                  nreq_gnt_o,
  output logic                  nrsp_gnt_o,
  output logic                  wide_gnt_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            sel_o,
  input  logic [QuotaWidth-1:0] cfg_narrow_quota_i,
  input  logic [QuotaWidth-1:0] cfg_wide_quota_i,
  input  logic                  stat_clr_i,
  output logic [StatWidth-1:0]  stat_nreq_o,
  output logic [StatWidth-1:0]  stat_nrsp_o,
  output logic [StatWidth-1:0]  stat_wide_o
);

  selected_channel_type_e class_q, class_d;
  sched_sel_e             rr_q, rr_d, sel_q, sel_d, sel;
  logic [QuotaWidth-1:0]  cnt_q, cnt_d;
  logic                   lock_q, lock_d;

  logic                   narrow_any, src_valid, hs;
  logic                   own_valid, other_valid, quota_hit, do_switch;
  logic [QuotaWidth:0]    cnt_inc, quota_lim;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      class_q <= narrowChan;
      cnt_q   <= '0;
      rr_q    <= SEL_NREQ;
      sel_q   <= SEL_NREQ;
      lock_q  <= 1'b0;
    end else begin
      class_q <= class_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    narrow_any = nreq_valid_i | nrsp_valid_i;

    // A stalled beat keeps its source; otherwise class rules pick one.
    // Narrow idle falls back to rr_q, whose valid is then low anyway.
    sel = rr_q;
    if (lock_q) begin
      sel = sel_q;
    end else if (class_q == wideChan) begin
      sel = SEL_WIDE;
    end else if (nreq_valid_i & nrsp_valid_i) begin
      sel = rr_q;
    end else if (nreq_valid_i) begin
      sel = SEL_NREQ;
    end else if (nrsp_valid_i) begin
      sel = SEL_NRSP;
    end

    case (sel)
      SEL_NREQ: src_valid = nreq_valid_i;
      SEL_NRSP: src_valid = nrsp_valid_i;
      SEL_WIDE: src_valid = wide_valid_i;
      default:  src_valid = 1'b0;
    endcase

    out_valid_o = ~rst_i & src_valid;
    sel_o       = rst_i ? SEL_NREQ : sel;
    hs          = out_valid_o & out_ready_i;
    nreq_gnt_o  = hs & (sel == SEL_NREQ);
    nrsp_gnt_o  = hs & (sel == SEL_NRSP);
    wide_gnt_o  = hs & (sel == SEL_WIDE);

    // Quota of 0 behaves as 1; compare one bit wider so cnt_q+1 never wraps.
    cnt_inc   = {1'b0, cnt_q} + 1'b1;
    quota_lim = (class_q == narrowChan) ? {1'b0, cfg_narrow_quota_i}
                                        : {1'b0, cfg_wide_quota_i};
    if (quota_lim == '0) begin
      quota_lim = {{QuotaWidth{1'b0}}, 1'b1};
    end
    quota_hit = cnt_inc >= quota_lim;

    own_valid   = (class_q == narrowChan) ? narrow_any : wide_valid_i;
    other_valid = (class_q == narrowChan) ? wide_valid_i : narrow_any;
    do_switch   = other_valid & ((hs & quota_hit) | (~own_valid & ~lock_q));

    class_d = class_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    lock_d  = lock_q;

    if (do_switch) begin
      class_d = (class_q == narrowChan) ? wideChan : narrowChan;
      cnt_d   = '0;
    end else if (hs && (cnt_q != '1)) begin
      cnt_d = cnt_inc[QuotaWidth-1:0];
    end

    if (hs && (class_q == narrowChan)) begin
      rr_d = (sel == SEL_NREQ) ? SEL_NRSP : SEL_NREQ;
    end

    if (hs) begin
      lock_d = 1'b0;
    end else if (out_valid_o) begin
      lock_d = 1'b1;
      sel_d  = sel;
    end
  end

  floo_sched_stat_cnt #(.Width(StatWidth)) u_stat_nreq (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (stat_clr_i),
    .inc_i (nreq_gnt_o),
    .cnt_o (stat_nreq_o)
  );

  floo_sched_stat_cnt #(.Width(StatWidth)) u_stat_nrsp (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (stat_clr_i),
    .inc_i (nrsp_gnt_o),
    .cnt_o (stat_nrsp_o)
  );

  floo_sched_stat_cnt #(.Width(StatWidth)) u_stat_wide (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (stat_clr_i),
    .inc_i (wide_gnt_o),
    .cnt_o (stat_wide_o)
  );

endmodule

// File: tb/tb_floo_axis_chan_scheduler.sv
// Bench for the AXIS channel scheduler: a source-level model predicts every
// cycle's outputs, plus directed sequences with literal grant orders.
module tb_floo_axis_chan_scheduler;

  localparam int QW = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          nreq_v, nrsp_v, wide_v;
  logic          nreq_g, nrsp_g, wide_g;
  logic          out_valid, out_ready;
  logic [1:0]    sel;
  logic [QW-1:0] nq, wq;
  logic          stat_clr;
  logic [SW-1:0] st_nreq, st_nrsp, st_wide;

  floo_axis_chan_scheduler #(.QuotaWidth(QW), .StatWidth(SW)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .nreq_valid_i       (nreq_v),
    .nrsp_valid_i       (nrsp_v),
    .wide_valid_i       (wide_v),
    .nreq_gnt_o         (nreq_g),
    .nrsp_gnt_o         (nrsp_g),
    .wide_gnt_o         (wide_g),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .sel_o              (sel),
    .cfg_narrow_quota_i (nq),
    .cfg_wide_quota_i   (wq),
    .stat_clr_i         (stat_clr),
    .stat_nreq_o        (st_nreq),
    .stat_nrsp_o        (st_nrsp),
    .stat_wide_o        (st_wide)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int glog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which class owns the link, beats served in it, next narrow turn,
  // the source held by a stalled beat (-1 none), and beats per source.
  bit m_wide;
  int m_served;
  int m_turn;
  int m_held;
  int m_cnt[3];

  always @(negedge clk) begin : model_cmp
    int v[3];
    int s, ov, hs, limit, own, other, sw;
    if (rst) begin
      m_wide = 0; m_served = 0; m_turn = 0; m_held = -1;
      m_cnt = '{0, 0, 0};
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_gnt", {29'd0, nreq_g, nrsp_g, wide_g}, 0);
      chk("rst_sel", {30'd0, sel}, 0);
      chk("rst_stats", {20'd0, st_nreq, st_nrsp, st_wide}, 0);
    end else begin
      v[0] = int'(nreq_v); v[1] = int'(nrsp_v); v[2] = int'(wide_v);
      if (m_held >= 0)           s = m_held;
      else if (m_wide)           s = 2;
      else if (v[0] != 0 && v[1] != 0) s = m_turn;
      else if (v[0] != 0)        s = 0;
      else if (v[1] != 0)        s = 1;
      else                       s = m_turn;
      ov = v[s];
      hs = (ov != 0 && out_ready) ? 1 : 0;

      chk("out_valid", {31'd0, out_valid}, ov);
      if (ov != 0) chk("sel", {30'd0, sel}, s);
      chk("nreq_gnt", {31'd0, nreq_g}, (hs != 0 && s == 0) ? 1 : 0);
      chk("nrsp_gnt", {31'd0, nrsp_g}, (hs != 0 && s == 1) ? 1 : 0);
      chk("wide_gnt", {31'd0, wide_g}, (hs != 0 && s == 2) ? 1 : 0);
      chk("stat_nreq", {28'd0, st_nreq}, m_cnt[0]);
      chk("stat_nrsp", {28'd0, st_nrsp}, m_cnt[1]);
      chk("stat_wide", {28'd0, st_wide}, m_cnt[2]);
      glog.push_back(nreq_g ? 1 : nrsp_g ? 2 : wide_g ? 3 : 0);

      if (stat_clr) m_cnt = '{0, 0, 0};
      else if (hs != 0) m_cnt[s] = (m_cnt[s] + 1) % (1 << SW);

      limit = m_wide ? int'(wq) : int'(nq);
      if (limit == 0) limit = 1;
      own   = m_wide ? v[2] : (v[0] | v[1]);
      other = m_wide ? (v[0] | v[1]) : v[2];
      sw = (other != 0 && ((hs != 0 && m_served + 1 >= limit) ||
                           (own == 0 && m_held < 0))) ? 1 : 0;

      if (!m_wide && hs != 0) m_turn = (s == 0) ? 1 : 0;
      if (hs != 0) m_held = -1;
      else if (ov != 0) m_held = s;
      if (sw != 0) begin
        m_served = 0;
        m_wide = !m_wide;
      end else if (hs != 0 && m_served < (1 << QW) - 1) begin
        m_served = m_served + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input int exp[]);
    chk({name, "_len"}, glog.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(name, (i < glog.size()) ? glog[i] : 99, exp[i]);
  endtask

  initial begin
    rst = 1'b1; nreq_v = 1'b1; nrsp_v = 1'b1; wide_v = 1'b1;
    out_ready = 1'b1; nq = '0; wq = '0; stat_clr = 1'b0;
    tick(2);
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_gnts", {29'd0, nreq_g, nrsp_g, wide_g}, 0);
    chk("reset_sel", {30'd0, sel}, 0);
    chk("reset_stat_wide", {28'd0, st_wide}, 0);
    rst = 1'b0;
    #1;
    chk("first_nreq_gnt", {31'd0, nreq_g}, 1);
    tick(3);

    // Round-robin between narrow sources.
    rst = 1'b1; wide_v = 1'b0; tick(1);
    rst = 1'b0; glog.delete();
    tick(6);
    nreq_v = 1'b0; nrsp_v = 1'b0;
    chk_log("rr_order", '{1, 2, 1, 2, 1, 2});
    chk("rr_stat_nreq", {28'd0, st_nreq}, 3);
    chk("rr_stat_nrsp", {28'd0, st_nrsp}, 3);

    // Quotas 2/3 with every source busy.
    rst = 1'b1; tick(1);
    nq = 4'd2; wq = 4'd3; nreq_v = 1'b1; nrsp_v = 1'b1; wide_v = 1'b1;
    rst = 1'b0; glog.delete();
    tick(10);
    nreq_v = 1'b0; nrsp_v = 1'b0; wide_v = 1'b0;
    chk_log("quota_order", '{1, 2, 3, 3, 3, 1, 2, 3, 3, 3});

    // Idle switch to wide costs one bubble.
    rst = 1'b1; tick(1);
    wide_v = 1'b1; rst = 1'b0; glog.delete();
    tick(3);
    wide_v = 1'b0;
    chk_log("idle_switch", '{0, 3, 3});

    // Stall lock holds nrsp while nreq appears with the turn on nreq.
    rst = 1'b1; tick(1);
    nrsp_v = 1'b1; out_ready = 1'b0; rst = 1'b0; glog.delete();
    tick(1);
    nreq_v = 1'b1; #1;
    chk("lock_sel_1", {30'd0, sel}, 1);
    tick(1);
    chk("lock_sel_2", {30'd0, sel}, 1);
    tick(1);
    out_ready = 1'b1; #1;
    chk("lock_nrsp_gnt", {31'd0, nrsp_g}, 1);
    tick(1);
    nrsp_v = 1'b0; #1;
    chk("after_lock_nreq_gnt", {31'd0, nreq_g}, 1);
    tick(1);
    nreq_v = 1'b0;
    chk_log("lock_order", '{0, 0, 0, 2, 1});

    // Reset during a locked stall drops the beat; source re-presents it.
    nrsp_v = 1'b1; out_ready = 1'b0; tick(2);
    rst = 1'b1; out_ready = 1'b1; #1;
    chk("midbeat_rst_valid", {31'd0, out_valid}, 0);
    chk("midbeat_rst_gnt", {31'd0, nrsp_g}, 0);
    tick(1);
    rst = 1'b0; #1;
    chk("represent_nrsp_gnt", {31'd0, nrsp_g}, 1);
    tick(1);
    nrsp_v = 1'b0;

    // Wide statistics wrap and clear priority.
    rst = 1'b1; tick(1);
    wide_v = 1'b1; rst = 1'b0;
    tick(16);
    chk("stat_wide_full", {28'd0, st_wide}, 15);
    tick(1);
    chk("stat_wide_wrap", {28'd0, st_wide}, 0);
    tick(3);
    chk("stat_wide_3", {28'd0, st_wide}, 3);
    stat_clr = 1'b1; #1;
    chk("clr_cycle_gnt", {31'd0, wide_g}, 1);
    tick(1);
    stat_clr = 1'b0;
    chk("stat_wide_clr", {28'd0, st_wide}, 0);
    tick(2);
    chk("stat_wide_after_clr", {28'd0, st_wide}, 2);
    wide_v = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
